// File: rtl/tetris_pkg.sv
// Shared types for the keyboard-to-command path: command encoding, FSM states,
// and the HID keycode decode.
package tetris_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_SOFT   = 3'd4,
    CMD_HARD   = 3'd5
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DAS    = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;

  function automatic cmd_t decode_key(input logic [7:0] code);
    cmd_t c;
    case (code)
      KEY_A:     c = CMD_LEFT;
      KEY_D:     c = CMD_RIGHT;
      KEY_W:     c = CMD_ROTATE;
      KEY_S:     c = CMD_SOFT;
      KEY_SPACE: c = CMD_HARD;
      default:   c = CMD_NONE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/frame_counter.sv
// Counts frame ticks up to a runtime limit; done pulses on the tick that reaches it
// and the count restarts from zero on that same edge.
module frame_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] cnt;

  // limit is at least 1, so limit-1 never underflows and cnt never wraps
  assign done = tick && (cnt == limit - 8'd1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= 8'd0;
    end else if (done) begin
      cnt <= 8'd0;
    end else if (tick) begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/key_repeat_ctrl.sv
// Keycode to game-command scheduler with delayed auto-shift: one command on press,
// a DAS pause, then one command every ARR frames while a repeatable key is held.
module key_repeat_ctrl
  import tetris_pkg::*;
#(
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] keycode,
  input  logic       frame_tick,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [1:0] state_dbg
);

  localparam logic [7:0] DAS_LIM = 8'(DAS_FRAMES);
  localparam logic [7:0] ARR_LIM = 8'(ARR_FRAMES);

  state_t     state, state_nxt;
  cmd_t       key_q, key_prev, cmd_q;
  logic       fire;
  logic       counting;
  logic       cnt_done;
  logic [7:0] cnt_limit;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q    <= CMD_NONE;
      key_prev <= CMD_NONE;
    end else begin
      key_q    <= decode_key(keycode);
      key_prev <= key_q;
    end
  end

  // The counter only runs while the same repeatable key stays held; any release,
  // key change or non-counting state holds it at zero.
  assign counting  = ((state == ST_DAS) || (state == ST_REPEAT)) &&
                     (key_q != CMD_NONE) && (key_q == key_prev);
  assign cnt_limit = (state == ST_DAS) ? DAS_LIM : ARR_LIM;

  frame_counter u_frame_counter (
    .clk   (clk),
    .reset (reset),
    .clear (!counting),
    .tick  (counting && frame_tick),
    .limit (cnt_limit),
    .done  (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    fire      = 1'b0;
    if (key_q == CMD_NONE) begin
      state_nxt = ST_IDLE;
    end else if ((state == ST_IDLE) || (key_q != key_prev)) begin
      fire      = 1'b1;
      state_nxt = ((key_q == CMD_ROTATE) || (key_q == CMD_HARD)) ? ST_HOLD : ST_DAS;
    end else if (counting && cnt_done) begin
      fire      = 1'b1;
      state_nxt = ST_REPEAT;
    end
  end

  // Valid/ready: cmd holds until a cycle with cmd_valid && cmd_ready; a fire that
  // arrives while an unaccepted command is pending is dropped, not queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid <= 1'b0;
      cmd_q     <= CMD_NONE;
    end else if (fire && (!cmd_valid || cmd_ready)) begin
      cmd_valid <= 1'b1;
      cmd_q     <= key_q;
    end else if (cmd_valid && cmd_ready) begin
      cmd_valid <= 1'b0;
      cmd_q     <= CMD_NONE;
    end
  end

  assign cmd       = cmd_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_key_repeat_ctrl.sv
// Bench for key_repeat_ctrl: directed scenarios plus random key/ready/tick traffic,
// each cycle compared against a tick-arithmetic reference model.
module tb_key_repeat_ctrl;

  localparam int DAS = 10;
  localparam int ARR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       frame_tick = 1'b0;
  logic       cmd_ready = 1'b1;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [1:0] state_dbg;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_kq = 0, m_prev = 0, m_ticks = 0, m_cmd = 0;
  bit m_valid = 1'b0;

  bit tick_en = 1'b0;
  int tick_gap = 0;
  int ticks_sent = 0;

  key_repeat_ctrl #(.DAS_FRAMES(DAS), .ARR_FRAMES(ARR)) dut (
    .clk        (clk),
    .reset      (reset),
    .keycode    (keycode),
    .frame_tick (frame_tick),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd        (cmd),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic int dec(input logic [7:0] c);
    case (c)
      8'h04: return 1;
      8'h07: return 2;
      8'h1A: return 3;
      8'h16: return 4;
      8'h2C: return 5;
      default: return 0;
    endcase
  endfunction

  // Model: a press fires at once; a held LEFT/RIGHT/SOFT fires again when the tick
  // count since press equals DAS, then every ARR ticks after that.
  always @(posedge clk) begin : model
    int k;
    bit f;
    if (reset) begin
      m_kq = 0; m_prev = 0; m_ticks = 0; m_valid = 1'b0; m_cmd = 0;
    end else begin
      k = m_kq;
      f = 1'b0;
      if (k != 0 && k != m_prev) begin
        f = 1'b1;
        m_ticks = 0;
      end else if ((k == 1 || k == 2 || k == 4) && frame_tick) begin
        m_ticks++;
        if (m_ticks == DAS || (m_ticks > DAS && (m_ticks - DAS) % ARR == 0)) f = 1'b1;
      end
      if (m_valid && cmd_ready) begin
        m_valid = 1'b0;
        m_cmd = 0;
      end
      if (f && !m_valid) begin
        m_valid = 1'b1;
        m_cmd = k;
      end
      m_prev = k;
      m_kq = dec(keycode);
    end
  end

  task automatic drive_tick();
    if (!tick_en) begin
      frame_tick = 1'b0;
    end else if (tick_gap == 0) begin
      frame_tick = 1'b1;
      ticks_sent++;
      tick_gap = $urandom_range(1, 3);
    end else begin
      frame_tick = 1'b0;
      tick_gap--;
    end
  endtask

  task automatic step();
    drive_tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; keycode = 8'h00; cmd_ready = 1'b1; tick_en = 1'b0;
    repeat (3) begin
      step();
      total++;
      if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
        bad++;
        $display("FAIL reset: cmd_valid=%b cmd=%0d, required 0/0", cmd_valid, cmd);
      end
    end
    reset = 1'b0;
    repeat (4) begin
      step();
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL reset_idle: cmd_valid=%b cmd=%0d, model %b/%0d", cmd_valid, cmd, m_valid, m_cmd);
      end
    end
  endtask

  task automatic test_left();
    int c = 0, t0, first = -1, nleft = 0, nother = 0, relc = 0;
    bit rel = 1'b0;
    cmd_ready = 1'b1; keycode = 8'h04; tick_en = 1'b0; t0 = ticks_sent;
    while (c < 800) begin
      step(); c++;
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL left_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (cmd_valid && first < 0) first = c;
      if (cmd_valid && cmd_ready) begin
        if (cmd == 3'd1) nleft++; else nother++;
      end
      if (c == 3) tick_en = 1'b1;
      if (ticks_sent - t0 >= 20) tick_en = 1'b0;
      if (!rel && ticks_sent - t0 >= 20 && !frame_tick) begin rel = 1'b1; keycode = 8'h00; relc = c; end
      if (rel && c - relc >= 6) break;
    end
    total++;
    if (first != 2) begin bad++; $display("FAIL left_latency: first valid at cycle %0d, required 2", first); end
    total++;
    if (!rel || nleft != 5 || nother != 0) begin
      bad++;
      $display("FAIL left_count: left=%0d other=%0d released=%b, required 5/0/1", nleft, nother, rel);
    end
  endtask

  task automatic test_rotate();
    int nrot = 0, nother = 0;
    cmd_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      int c = 0, t0, relc = 0;
      bit rel = 1'b0;
      keycode = 8'h1A; tick_en = 1'b0; t0 = ticks_sent;
      while (c < 800) begin
        step(); c++;
        total++;
        if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
          bad++;
          $display("FAIL rotate_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
        end
        if (cmd_valid && cmd_ready) begin
          if (cmd == 3'd3) nrot++; else nother++;
        end
        if (c == 3) tick_en = 1'b1;
        if (ticks_sent - t0 >= 30) tick_en = 1'b0;
        if (!rel && ticks_sent - t0 >= 30 && !frame_tick) begin rel = 1'b1; keycode = 8'h00; relc = c; end
        if (rel && c - relc >= 5) break;
      end
      total++;
      if (!rel) begin bad++; $display("FAIL rotate_timeout: press %0d never finished 30 ticks", p); end
    end
    total++;
    if (nrot != 2 || nother != 0) begin
      bad++;
      $display("FAIL rotate_count: rotate=%0d other=%0d, required 2/0", nrot, nother);
    end
  endtask

  task automatic test_backpressure();
    int c = 0, t0, relc = 0, nhs = 0, drops = 0;
    bit rel = 1'b0, seen = 1'b0;
    cmd_ready = 1'b0; keycode = 8'h07; tick_en = 1'b0; t0 = ticks_sent;
    while (c < 800) begin
      step(); c++;
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL bp_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (cmd_valid) seen = 1'b1; else if (seen) drops++;
      if (c == 3) tick_en = 1'b1;
      if (ticks_sent - t0 >= 15) tick_en = 1'b0;
      if (!rel && ticks_sent - t0 >= 15 && !frame_tick) begin rel = 1'b1; keycode = 8'h00; relc = c; end
      if (rel && c - relc >= 4) break;
    end
    total++;
    if (!rel || drops != 0 || cmd_valid !== 1'b1 || cmd !== 3'd2) begin
      bad++;
      $display("FAIL bp_hold: cmd_valid=%b cmd=%0d drops=%0d, required 1/2/0", cmd_valid, cmd, drops);
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (cmd_valid && cmd_ready) nhs++;
      step();
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL bp_drain_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
    end
    total++;
    if (nhs != 1 || cmd_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: handshakes=%0d cmd_valid=%b, required 1/0", nhs, cmd_valid);
    end
  endtask

  task automatic test_switch();
    int c = 0, t0, t1 = 0, swc = -1, relc = 0, first_r = -1, tick_at = -1;
    int nleft = 0, nright = 0, nother = 0;
    bit rel = 1'b0;
    cmd_ready = 1'b1; keycode = 8'h04; tick_en = 1'b0; t0 = ticks_sent;
    while (c < 800) begin
      step(); c++;
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL switch_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (cmd_valid) begin
        if (cmd == 3'd1) nleft++;
        else if (cmd == 3'd2) begin
          nright++;
          if (nright == 1) first_r = c;
          if (nright == 2) tick_at = ticks_sent - t1;
        end else nother++;
      end
      if (c == 3) tick_en = 1'b1;
      if (swc < 0 && ticks_sent - t0 >= 5) tick_en = 1'b0;
      if (swc < 0 && ticks_sent - t0 >= 5 && !frame_tick) begin keycode = 8'h07; swc = c; end
      if (swc >= 0 && c == swc + 3) begin tick_en = 1'b1; t1 = ticks_sent; end
      if (swc >= 0 && c > swc + 3 && ticks_sent - t1 >= 10) tick_en = 1'b0;
      if (swc >= 0 && c > swc + 3 && !rel && ticks_sent - t1 >= 10 && !frame_tick) begin
        rel = 1'b1; keycode = 8'h00; relc = c;
      end
      if (rel && c - relc >= 5) break;
    end
    total++;
    if (!rel || first_r - swc != 2) begin
      bad++;
      $display("FAIL switch_latency: RIGHT at +%0d cycles after switch, required +2", first_r - swc);
    end
    total++;
    if (tick_at != DAS) begin
      bad++;
      $display("FAIL switch_das: second RIGHT after %0d ticks, required %0d", tick_at, DAS);
    end
    total++;
    if (nleft != 1 || nright != 2 || nother != 0) begin
      bad++;
      $display("FAIL switch_count: left=%0d right=%0d other=%0d, required 1/2/0", nleft, nright, nother);
    end
  endtask

  task automatic test_reset_mid();
    int c = 0, t0;
    cmd_ready = 1'b0; keycode = 8'h16; tick_en = 1'b0; t0 = ticks_sent;
    while (c < 800) begin
      step(); c++;
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL rmid_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (c == 3) tick_en = 1'b1;
      if (ticks_sent - t0 >= 15) tick_en = 1'b0;
      if (ticks_sent - t0 >= 15 && !frame_tick) break;
    end
    total++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
      bad++;
      $display("FAIL rmid_pending: cmd_valid=%b cmd=%0d, required 1/4", cmd_valid, cmd);
    end
    reset = 1'b1;
    step();
    total++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
      bad++;
      $display("FAIL rmid_reset: cmd_valid=%b cmd=%0d, required 0/0", cmd_valid, cmd);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 1) begin
        total++;
        if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rmid_early: cmd_valid=%b one cycle after reset, required 0", cmd_valid); end
      end
      if (i == 2) begin
        total++;
        if (cmd_valid !== 1'b1 || cmd !== 3'd4) begin
          bad++;
          $display("FAIL rmid_refire: cmd_valid=%b cmd=%0d two cycles after reset, required 1/4", cmd_valid, cmd);
        end
      end
    end
    keycode = 8'h00; cmd_ready = 1'b1;
    repeat (4) begin
      step();
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL rmid_drain @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
    end
  endtask

  task automatic test_unmapped();
    int c = 0, t0, swc = -1, t1 = 0, relc = 0, nbefore = 0, nhard = 0, nother = 0;
    bit rel = 1'b0;
    cmd_ready = 1'b1; keycode = 8'h29; tick_en = 1'b1; t0 = ticks_sent;
    while (c < 1200) begin
      step(); c++;
      total++;
      if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
        bad++;
        $display("FAIL unmapped_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
      end
      if (cmd_valid) begin
        if (swc < 0) nbefore++;
        else if (cmd == 3'd5) nhard++;
        else nother++;
      end
      if (swc < 0 && ticks_sent - t0 >= 15) begin keycode = 8'h2C; swc = c; t1 = ticks_sent; end
      if (swc >= 0 && !rel && ticks_sent - t1 >= 10) begin rel = 1'b1; keycode = 8'h00; relc = c; tick_en = 1'b0; end
      if (rel && c - relc >= 5) break;
    end
    total++;
    if (!rel || nbefore != 0) begin
      bad++;
      $display("FAIL unmapped_quiet: %0d valid cycles on key 0x29, required 0", nbefore);
    end
    total++;
    if (nhard != 1 || nother != 0) begin
      bad++;
      $display("FAIL unmapped_hard: hard=%0d other=%0d, required 1/0", nhard, nother);
    end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 7))
        0: keycode = 8'h00;
        1: keycode = 8'h04;
        2: keycode = 8'h07;
        3: keycode = 8'h1A;
        4: keycode = 8'h16;
        5: keycode = 8'h2C;
        6: keycode = 8'h29;
        default: keycode = 8'($urandom);
      endcase
      len = $urandom_range(1, 50);
      for (int i = 0; i < len; i++) begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        reset = ($urandom_range(0, 199) == 0);
        tick_en = 1'b1;
        step();
        total++;
        if (cmd_valid !== m_valid || (m_valid && cmd !== 3'(m_cmd))) begin
          bad++;
          $display("FAIL random_model @%0t: cmd_valid=%b cmd=%0d, model %b/%0d", $time, cmd_valid, cmd, m_valid, m_cmd);
        end
      end
    end
    reset = 1'b0; keycode = 8'h00; cmd_ready = 1'b1; tick_en = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_left();
    test_rotate();
    test_backpressure();
    test_switch();
    test_reset_mid();
    test_unmapped();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
